ram_1b_port_ctrl: RTL
=====================

// Module: ram_1b_port_ctrl
// PURPOSE
//  Controller for a small 1-bit-wide, 1R1W memory macro whose array has no reset.
//  After reset it sweeps the array to a known value.
//  It then shares the single write port between two requesters (round-robin).
//  It serves one read requester with a registered, write-first (bypassed) response.
//  It sits between BOOM-side state-bit producers/consumers and the memory's R0/W0 ports.
// PARAMETERS
//  DEPTH     3  number of memory entries (legal addresses 0..DEPTH-1)
//  ADDR_W    2  address width, >= clog2(DEPTH)
//  INIT_VAL  0  1-bit value written to every entry during the init sweep
// PORTS
//  clock          in   1       single clock; all state on posedge
//  reset          in   1       asynchronous, active-high
//  wr0_valid      in   1       requester 0 write request
//  wr0_ready      out  1       requester 0 write accepted this cycle
//  wr0_addr       in   ADDR_W  requester 0 write address
//  wr0_data       in   1       requester 0 write data
//  wr1_valid/ready/addr/data   as wr0_*, requester 1
//  rd_valid       in   1       read request
//  rd_ready       out  1       read accepted this cycle
//  rd_addr        in   ADDR_W  read address
//  rsp_valid      out  1       read response valid (1-cycle pulse)
//  rsp_data       out  1       read response data
//  init_done      out  1       high once the init sweep is complete
//  err_oor        out  1       sticky: an out-of-range address was accepted
//  mem_W0_en      out  1       memory write enable
//  mem_W0_addr    out  ADDR_W  memory write address
//  mem_W0_data    out  1       memory write data
//  mem_R0_en      out  1       memory read enable
//  mem_R0_addr    out  ADDR_W  memory read address
//  mem_R0_data    in   1       memory read data (combinational from R0_addr)
// BEHAVIOUR
//  Reset values:
//   - state=INIT, sweep_cnt=0, rr_ptr=0.
//   - init_done=0, err_oor=0, rsp_valid=0, rsp_data=0.
//  Reset asserted mid-operation:
//   - all of the above is forced immediately.
//   - any pending response is dropped; the array is re-swept after reset deasserts.
//  INIT state:
//   - each cycle: mem_W0_en=1, mem_W0_addr=sweep_cnt, mem_W0_data=INIT_VAL; sweep_cnt++.
//   - wr*_ready=0 and rd_ready=0.
//   - the sweep_cnt==DEPTH-1 write moves state to RUN on the next cycle.
//   - sweep takes exactly DEPTH cycles after reset deasserts.
//  RUN state: init_done=1, terminal (left only by reset).
//  Write arbitration (RUN):
//   - one valid -> that requester is granted.
//   - both valid -> rr_ptr's requester is granted.
//   - rr_ptr <= ~granted index after any grant; rr_ptr is unchanged when idle.
//   - wrN_ready = grantN (combinational; a transfer is valid&ready).
//   - the granted request drives mem_W0_*.
//  Out-of-range write (addr>=DEPTH):
//   - the request is granted (ready=1) but mem_W0_en=0.
//   - err_oor sets on the next edge.
//  Read (RUN):
//   - rd_ready=1 always; mem_R0_en=rd_valid, mem_R0_addr=rd_addr.
//   - rsp_valid is registered, 1 cycle after acceptance; a new read is allowed every cycle.
//  Read bypass (write-first):
//   - an accepted read and a granted in-range write to the same address in the same cycle
//     -> rsp_data = write data.
//   - otherwise rsp_data = mem_R0_data captured at the edge.
//  Out-of-range read: rsp_valid=1, rsp_data=0, err_oor sets.
//  mem_W0_en=0 and mem_R0_en=0 whenever there is no transfer.
// TESTING
//  1. Reset release, DEPTH=3, INIT_VAL=1:
//     -> mem_W0_en=1 for 3 cycles, addr 0,1,2, data 1.
//     -> init_done rises on cycle 4; then reads of 0..2 all return 1.
//  2. Both writers valid for 4 cycles (rr_ptr=0):
//     -> grants 0,1,0,1; memory receives the wr0/wr1 data in that order.
//  3. Same-cycle wr0 (addr1, data 1) and rd (addr1), entry previously 0:
//     -> next cycle rsp_valid=1, rsp_data=1.
//     -> a read of addr1 one cycle later also returns 1.
//  4. Write addr=3 and read addr=3:
//     -> mem_W0_en=0, rsp_data=0, err_oor=1, and it stays 1 until reset.
//  5. Assert reset during RUN with a read in flight:
//     -> rsp_valid=0 immediately, init_done=0.
//     -> after release, a full 3-cycle sweep runs and no stale response appears.
//  6. Back-to-back reads 0,1,2 for 3 cycles:
//     -> rsp_valid high 3 consecutive cycles with the matching data, 1-cycle latency.

Source files
------------

// File: rtl/ram_1b_port_ctrl.sv
// Controller for a 1-bit 1R1W memory macro: post-reset init sweep, round-robin
// sharing of the write port between two requesters, and a write-first registered read.
module ram_1b_port_ctrl #(
  parameter int   DEPTH    = 3,
  parameter int   ADDR_W   = 2,
  parameter logic INIT_VAL = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr0_valid,
  output logic              wr0_ready,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic              wr0_data,
  input  logic              wr1_valid,
  output logic              wr1_ready,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic              wr1_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  output logic              rsp_data,
  output logic              init_done,
  output logic              err_oor,
  output logic              mem_W0_en,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic              mem_W0_data,
  output logic              mem_R0_en,
  output logic [ADDR_W-1:0] mem_R0_addr,
  input  logic              mem_R0_data
);

  localparam logic [0:0]        ST_INIT  = 1'b0;
  localparam logic [0:0]        ST_RUN   = 1'b1;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              rr_ptr;

  logic              run;
  logic              grant0;
  logic              grant1;
  logic              w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic              w_data;
  logic              w_in_range;
  logic              w_fire;
  logic              rd_fire;
  logic              rd_in_range;
  logic              bypass;

  assign run       = (state == ST_RUN);
  assign init_done = run;

  // Lone requester always wins; on contention rr_ptr names the winner.
  assign grant0  = run & wr0_valid & (~wr1_valid | ~rr_ptr);
  assign grant1  = run & wr1_valid & (~wr0_valid |  rr_ptr);
  assign w_grant = grant0 | grant1;

  assign wr0_ready = grant0;
  assign wr1_ready = grant1;

  assign w_addr     = grant1 ? wr1_addr : wr0_addr;
  assign w_data     = grant1 ? wr1_data : wr0_data;
  assign w_in_range = ({1'b0, w_addr} < DEPTH_C);
  assign w_fire     = w_grant & w_in_range;

  assign rd_ready    = run;
  assign rd_fire     = run & rd_valid;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
  assign bypass      = w_fire & (w_addr == rd_addr);

  assign mem_R0_en   = rd_fire;
  assign mem_R0_addr = rd_fire ? rd_addr : '0;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    mem_W0_en   = 1'b0;
    mem_W0_addr = '0;
    mem_W0_data = 1'b0;
    if (!run) begin
      mem_W0_en   = 1'b1;
      mem_W0_addr = sweep_cnt;
      mem_W0_data = INIT_VAL;
    end else if (w_grant) begin
      // Out-of-range grants still complete the handshake but never reach the array.
      mem_W0_en   = w_in_range;
      mem_W0_addr = w_addr;
      mem_W0_data = w_data;
    end
  end

  // NOTE: the macro array has no reset; the INIT sweep is what gives it a known value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      rr_ptr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 1'b0;
      err_oor   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (!run) begin
        sweep_cnt <= sweep_cnt + 1'b1;
        if (sweep_cnt == LAST_IDX) state <= ST_RUN;
      end

      if (grant0)      rr_ptr <= 1'b1;
      else if (grant1) rr_ptr <= 1'b0;

      rsp_valid <= rd_fire;
      if (rd_fire) begin
        if (!rd_in_range) rsp_data <= 1'b0;
        else if (bypass)  rsp_data <= w_data;
        else              rsp_data <= mem_R0_data;
      end

      if ((w_grant && !w_in_range) || (rd_fire && !rd_in_range)) err_oor <= 1'b1;
    end
  end

endmodule
